hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers.
REQ-002 Parameter AW, default 5: register-index width; SHALL satisfy 2^AW >= NREG.
REQ-003 Parameter TW, default 2: Tnew/Tuse counter width.
REQ-004 Parameter MUL_LAT, default 5: multiply busy cycles.
REQ-005 Parameter DIV_LAT, default 10: divide busy cycles.
REQ-006 Parameter MW, default 4: MD busy-counter width; SHALL hold max(MUL_LAT, DIV_LAT).
REQ-007 clk  in  1  single clock; all state updates on the rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 id_valid  in  1  a valid instruction occupies ID.
REQ-010 id_rs, id_rt  in  AW each  source registers of the ID instruction.
REQ-011 id_rs_use, id_rt_use  in  1 each  the corresponding source is actually read.
REQ-012 id_tuse_rs, id_tuse_rt  in  TW each  cycles until each source is consumed.
REQ-013 id_rd  in  AW  destination register.
REQ-014 id_tnew  in  TW  cycles, counted from EX entry, until the result is forwardable.
REQ-015 id_md_start  in  1  the ID instruction starts multiply/divide.
REQ-016 id_md_div  in  1  the start is a divide (otherwise a multiply).
REQ-017 id_hilo  in  1  the ID instruction reads or writes HI/LO.
REQ-018 freeze  in  1  global pipeline hold (memory wait).
REQ-019 stall  out  1  hold IF/ID and insert an EX bubble.
REQ-020 stall_raw, stall_md  out  1 each  stall cause flags.
REQ-021 md_busy  out  1  MD busy counter is nonzero.

Function
REQ-022 Per register r, the block SHALL hold a TW-bit pending counter cnt[r]; cnt[0] SHALL be constant 0.
REQ-023 issue SHALL equal id_valid & ~stall & ~freeze.
REQ-024 On issue with id_rd != 0, cnt[id_rd] SHALL load id_tnew, taking priority over decrement of the same entry.
REQ-025 Every other nonzero cnt SHALL decrement by 1 per cycle when freeze=0; cnt SHALL saturate at 0.
REQ-026 stall_raw SHALL assert (combinationally, same cycle) when id_valid and a used source s != 0 has cnt[s] > its Tuse.
REQ-027 On issue with id_md_start, mdcnt SHALL load MUL_LAT or DIV_LAT according to id_md_div.
REQ-028 A nonzero mdcnt SHALL decrement by 1 per cycle when freeze=0.
REQ-029 stall_md SHALL equal id_valid & (id_hilo | id_md_start) & (mdcnt != 0).
REQ-030 stall SHALL equal stall_raw | stall_md; md_busy SHALL equal (mdcnt != 0).
REQ-031 While freeze=1, all counters SHALL hold, no issue SHALL occur, and stall outputs SHALL still reflect the current state.
REQ-032 A stalled instruction SHALL NOT modify any counter; it is re-evaluated each cycle until the stall clears.
REQ-033 id_tnew = 0 SHALL leave cnt[id_rd] = 0 (result ready in EX; no hazard).
REQ-034 On a second issue to the same rd, the newer Tnew SHALL overwrite the older one (youngest writer wins).

Reset
REQ-035 When reset=1 at a clock edge, all cnt and mdcnt SHALL be 0, including mid-divide or mid-hazard.
REQ-036 After reset, stall, stall_raw, stall_md and md_busy SHALL be 0 until a new issue occurs.
REQ-037 Reset SHALL take priority over issue and freeze in the same cycle.

Structure
REQ-038 Package hazard_pkg SHALL hold the Tnew/Tuse class constants (TUSE_BRANCH=0, TUSE_ALU=1, TUSE_STORE=2, TNEW_ALU=1, TNEW_LOAD=2) and default latencies.
REQ-039 The per-register counter with load, decrement and saturate SHALL be a sub-module sb_entry, instantiated NREG-1 times via generate.
REQ-040 Instruction decode SHALL remain outside this block.

Verification
REQ-041 Issue a load, rd=8, tnew=2; next cycle an ALU op reading r8 (tuse=1) -> stall=1 for one cycle, then 0 and the ALU op issues.
REQ-042 Issue an ALU op, rd=9, tnew=1; next cycle a branch reading r9 (tuse=0) -> stall_raw=1 for one cycle, then 0.
REQ-043 Issue a divide (DIV_LAT=10); immediately follow with mfhi -> stall_md=1 for exactly 10 cycles; md_busy falls in the same cycle that stall_md falls.
REQ-044 Issue a load to r0, then a consumer of r0 -> stall never asserts.
REQ-045 Load r8 with tnew=2, then hold freeze=1 for 3 cycles with a consumer of r8 (tuse=1) in ID -> stall stays 1 throughout and cnt[8] holds at 2; after freeze drops, stall clears one cycle later.
REQ-046 Assert reset during a multiply at mdcnt=3 -> the next cycle md_busy=0 and an mflo in ID issues without stalling.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Tnew/Tuse class constants and default MD latencies shared by
//            the hazard scoreboard and its users.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Tuse: cycles after ID until the operand is consumed
    localparam logic [1:0] TUSE_BRANCH = 2'd0;
    localparam logic [1:0] TUSE_ALU    = 2'd1;
    localparam logic [1:0] TUSE_STORE  = 2'd2;

    // Tnew: cycles after EX entry until the result can be forwarded
    localparam logic [1:0] TNEW_ALU    = 2'd1;
    localparam logic [1:0] TNEW_LOAD   = 2'd2;

    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 10;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/sb_entry.sv
`default_nettype none
// ============================================================================
// Module   : sb_entry
// Brief    : One register's pending-result counter: load on issue, otherwise
//            count down to zero while the pipeline is not frozen.
// Revision : 1.0 - initial release
// ============================================================================
module sb_entry #(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [TW-1:0] i_tnew,
    input  logic          i_freeze,
    output logic [TW-1:0] o_cnt
);

    logic [TW-1:0] r_cnt;

    // Load wins over decrement so the youngest writer's Tnew is kept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_tnew;
        end else if (!i_freeze && (r_cnt != '0)) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule : sb_entry
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Tnew/Tuse RAW hazard tracking per register plus a multiply/divide
//            busy counter; produces the ID-stage stall and its causes.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int TW      = 2,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int MW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_rs_use,
    input  logic          id_rt_use,
    input  logic [TW-1:0] id_tuse_rs,
    input  logic [TW-1:0] id_tuse_rt,
    input  logic [AW-1:0] id_rd,
    input  logic [TW-1:0] id_tnew,
    input  logic          id_md_start,
    input  logic          id_md_div,
    input  logic          id_hilo,
    input  logic          freeze,
    output logic          stall,
    output logic          stall_raw,
    output logic          stall_md,
    output logic          md_busy
);

    localparam int          c_nslot   = 2 ** AW;
    localparam logic [MW-1:0] c_mul_lat = MW'(MUL_LAT);
    localparam logic [MW-1:0] c_div_lat = MW'(DIV_LAT);

    logic [TW-1:0] w_cnt [c_nslot];
    logic          w_issue;
    logic          w_rs_haz;
    logic          w_rt_haz;
    logic [MW-1:0] r_mdcnt;

    assign w_issue = id_valid & ~stall & ~freeze;

    // Slots beyond NREG exist only so any AW-bit index reads a defined zero
    for (genvar r = 0; r < c_nslot; r++) begin : g_slot
        if ((r == 0) || (r >= NREG)) begin : g_zero
            assign w_cnt[r] = '0;
        end else begin : g_reg
            sb_entry #(
                .TW (TW)
            ) u_entry (
                .clk      (clk),
                .rst      (reset),
                .i_load   (w_issue && (id_rd == AW'(r))),
                .i_tnew   (id_tnew),
                .i_freeze (freeze),
                .o_cnt    (w_cnt[r])
            );
        end
    end

    assign w_rs_haz = id_rs_use && (id_rs != '0) && (w_cnt[id_rs] > id_tuse_rs);
    assign w_rt_haz = id_rt_use && (id_rt != '0) && (w_cnt[id_rt] > id_tuse_rt);

    assign stall_raw = id_valid & (w_rs_haz | w_rt_haz);
    assign md_busy   = (r_mdcnt != '0);
    assign stall_md  = id_valid & (id_hilo | id_md_start) & md_busy;
    assign stall     = stall_raw | stall_md;

    // A new MD op can only issue once the unit is idle, so load never races decrement
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mdcnt <= '0;
        end else if (w_issue && id_md_start) begin
            r_mdcnt <= id_md_div ? c_div_lat : c_mul_lat;
        end else if (!freeze && md_busy) begin
            r_mdcnt <= r_mdcnt - MW'(1);
        end
    end

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed-vector bench for hazard_scoreboard; outputs are checked
//            as {stall, stall_raw, stall_md, md_busy} before each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_rs_use, id_rt_use;
    logic [1:0] id_tuse_rs, id_tuse_rt, id_tnew;
    logic       id_md_start, id_md_div, id_hilo, freeze;
    logic       stall, stall_raw, stall_md, md_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u_dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_use   (id_rs_use),
        .id_rt_use   (id_rt_use),
        .id_tuse_rs  (id_tuse_rs),
        .id_tuse_rt  (id_tuse_rt),
        .id_rd       (id_rd),
        .id_tnew     (id_tnew),
        .id_md_start (id_md_start),
        .id_md_div   (id_md_div),
        .id_hilo     (id_hilo),
        .freeze      (freeze),
        .stall       (stall),
        .stall_raw   (stall_raw),
        .stall_md    (stall_md),
        .md_busy     (md_busy)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_use = 0; id_rt_use = 0; id_tuse_rs = 0; id_tuse_rt = 0;
        id_tnew = 0; id_md_start = 0; id_md_div = 0; id_hilo = 0;
    endtask

    // ALU/load style instruction: one source (rs) and a destination
    task automatic op(input logic [4:0] rs, input logic rs_use, input logic [1:0] tuse,
                      input logic [4:0] rd, input logic [1:0] tnew);
        idle();
        id_valid = 1; id_rs = rs; id_rs_use = rs_use; id_tuse_rs = tuse;
        id_rd = rd; id_tnew = tnew;
    endtask

    task automatic md_op(input logic start, input logic div, input logic hilo);
        idle();
        id_valid = 1; id_md_start = start; id_md_div = div; id_hilo = hilo;
    endtask

    // Settle, compare the current-cycle outputs, then advance one clock
    task automatic chk_step(input string tag, input logic [3:0] exp);
        #1;
        check(tag, {stall, stall_raw, stall_md, md_busy}, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        freeze = 0;
        reset  = 1;
        step();
        step();
        reset = 0;
        chk_step("reset_state", 4'b0000);

        // load r8 (tnew=2) then ALU reader of r8: one stall cycle
        op(5'd0, 0, 2'd0, 5'd8, TNEW_LOAD);
        chk_step("ld_r8_issue", 4'b0000);
        op(5'd8, 1, TUSE_ALU, 5'd10, TNEW_ALU);
        chk_step("alu_r8_stall", 4'b1100);
        chk_step("alu_r8_go", 4'b0000);
        idle(); step();

        // ALU r9 (tnew=1) then branch reading r9 via rt (tuse=0)
        op(5'd0, 0, 2'd0, 5'd9, TNEW_ALU);
        chk_step("alu_r9_issue", 4'b0000);
        idle();
        id_valid = 1; id_rt = 5'd9; id_rt_use = 1; id_tuse_rt = TUSE_BRANCH;
        chk_step("br_r9_stall", 4'b1100);
        chk_step("br_r9_go", 4'b0000);
        idle(); step();

        // unused source never stalls
        op(5'd0, 0, 2'd0, 5'd11, TNEW_LOAD);
        step();
        op(5'd11, 0, TUSE_BRANCH, 5'd0, 2'd0);
        chk_step("unused_src", 4'b0000);
        idle(); step();

        // divide then mfhi: stall_md for exactly DIV_LAT cycles
        md_op(1, 1, 1);
        chk_step("div_issue", 4'b0000);
        md_op(0, 0, 1);
        for (int i = 0; i < DEF_DIV_LAT; i++) chk_step($sformatf("mfhi_wait%0d", i), 4'b1011);
        chk_step("mfhi_go", 4'b0000);

        // multiply then mflo: MUL_LAT cycles
        md_op(1, 0, 1);
        step();
        md_op(0, 0, 1);
        for (int i = 0; i < DEF_MUL_LAT; i++) chk_step($sformatf("mflo_wait%0d", i), 4'b1011);
        chk_step("mflo_go", 4'b0000);
        idle(); chk_step("md_idle", 4'b0000);

        // writes to r0 never create a hazard
        op(5'd0, 0, 2'd0, 5'd0, TNEW_LOAD);
        step();
        op(5'd0, 1, TUSE_BRANCH, 5'd1, TNEW_ALU);
        chk_step("r0_consumer", 4'b0000);
        idle(); step();

        // tnew=0 leaves the register ready
        op(5'd0, 0, 2'd0, 5'd12, 2'd0);
        step();
        op(5'd12, 1, TUSE_BRANCH, 5'd0, 2'd0);
        chk_step("tnew0_consumer", 4'b0000);
        idle(); step();

        // youngest writer wins: tnew=1 then tnew=2 to r5
        op(5'd0, 0, 2'd0, 5'd5, 2'd1);
        step();
        op(5'd0, 0, 2'd0, 5'd5, 2'd2);
        chk_step("r5_rewrite", 4'b0000);
        op(5'd5, 1, TUSE_ALU, 5'd0, 2'd0);
        chk_step("r5_stall", 4'b1100);
        chk_step("r5_go", 4'b0000);
        idle(); step();

        // freeze holds counters and keeps stall visible
        op(5'd0, 0, 2'd0, 5'd8, TNEW_LOAD);
        step();
        op(5'd8, 1, TUSE_ALU, 5'd0, 2'd0);
        freeze = 1;
        for (int i = 0; i < 3; i++) chk_step($sformatf("freeze_hold%0d", i), 4'b1100);
        freeze = 0;
        chk_step("unfreeze_stall", 4'b1100);
        chk_step("unfreeze_go", 4'b0000);
        idle(); step();

        // reset mid-multiply at mdcnt=3
        md_op(1, 0, 0);
        step();
        idle(); step();
        idle(); step();
        md_op(1, 1, 0);
        reset = 1;
        chk_step("rst_mid_mul", 4'b1011);
        reset = 0;
        md_op(0, 0, 1);
        chk_step("mflo_after_rst", 4'b0000);

        // reset beats an issue in the same cycle
        op(5'd0, 0, 2'd0, 5'd7, TNEW_LOAD);
        reset = 1;
        step();
        reset = 0;
        op(5'd7, 1, TUSE_BRANCH, 5'd0, 2'd0);
        chk_step("rst_beats_issue", 4'b0000);
        idle();
        chk_step("final_idle", 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_hazard_scoreboard
`default_nettype wire
